// File: rtl/clk_mon_pkg.sv
// Shared channel state encoding and default timing constants for the divided-clock ratio monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } chan_state_e;

  localparam int W_HALF_DEF     = 1;
  localparam int R_HALF_DEF     = 3;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int CNT_W_DEF      = 8;

  // A run this long without an edge means the monitored clock is stuck.
  function automatic int timeout_len(input int exp_half);
    return 2 * exp_half + 1;
  endfunction

endpackage

// File: rtl/clk_ratio_chan.sv
// One monitored clock: two-flop edge sampler, saturating run counter, lock/fault FSM
// and the most recent measured half-period.
module clk_ratio_chan
  import clk_mon_pkg::*;
#(
  parameter int EXP        = W_HALF_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] last_run
);

  localparam logic [CNT_W-1:0] EXP_V     = CNT_W'(EXP);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(timeout_len(EXP));
  localparam logic [CNT_W-1:0] LOCK_V    = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             s_q;
  logic             p_q;
  logic             tog;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] good_next;
  logic             timeout;
  logic             bad_run;
  logic             err;
  chan_state_e      state;
  chan_state_e      state_next;

  // The monitored clock is plain data here; the first flop doubles as synchroniser.
  // NOTE: every flop uses non-blocking assignment so s_q/p_q read their old values
  // within the same edge, giving a true two-stage pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      s_q <= mon_in;
      p_q <= s_q;
    end
  end

  assign tog = s_q ^ p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (tog) begin
      run_cnt <= CNT_W'(1);
    end else if (run_cnt != CNT_MAX) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  // Equality (not >=) makes the timeout a single-cycle event per stuck run.
  assign timeout = !tog && (run_cnt == TIMEOUT_V);
  assign bad_run = tog && (run_cnt != EXP_V);
  assign err     = bad_run || timeout;

  // NOTE: both next-state values get defaults before the case so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    unique case (state)
      ST_IDLE: begin
        if (tog) begin
          state_next = ST_MEASURE;
          good_next  = '0;
        end
      end
      ST_MEASURE: begin
        if (err) begin
          good_next = '0;
        end else if (tog) begin
          good_next = good_cnt + CNT_W'(1);
          if (good_next == LOCK_V) begin
            state_next = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (err) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        // A fresh fault in the clearing cycle keeps the channel in FAULT.
        if (clr_err && !err) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      good_cnt <= '0;
      locked   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      locked   <= (state_next == ST_LOCKED);
      fault    <= (state_next == ST_FAULT);
    end
  end

  // The run ending at the first edge after IDLE started at an arbitrary point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_run <= '0;
    end else if (tog && (state != ST_IDLE)) begin
      last_run <= run_cnt;
    end
  end

endmodule

// File: rtl/clk_ratio_monitor.sv
// Checks the divided FIFO write (/2) and read (/6) clocks against clk and reports
// per-channel lock and sticky fault status plus a combined lock flag.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int W_HALF     = W_HALF_DEF,
  parameter int R_HALF     = R_HALF_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wclk_in,
  input  logic             rclk_in,
  input  logic             clr_err,
  output logic             w_locked,
  output logic             r_locked,
  output logic             all_locked,
  output logic             w_fault,
  output logic             r_fault,
  output logic [CNT_W-1:0] w_last_run,
  output logic [CNT_W-1:0] r_last_run
);

  clk_ratio_chan #(
    .EXP        (W_HALF),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_wchan (
    .clk      (clk),
    .rst_n    (rst_n),
    .mon_in   (wclk_in),
    .clr_err  (clr_err),
    .locked   (w_locked),
    .fault    (w_fault),
    .last_run (w_last_run)
  );

  clk_ratio_chan #(
    .EXP        (R_HALF),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_rchan (
    .clk      (clk),
    .rst_n    (rst_n),
    .mon_in   (rclk_in),
    .clr_err  (clr_err),
    .locked   (r_locked),
    .fault    (r_fault),
    .last_run (r_last_run)
  );

  // Registered so downstream enables see a clean flop output one cycle after both lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= w_locked & r_locked;
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench: the driver pushes per-cycle expectations from an edge-timestamp
// reference model; an independent monitor pops and compares every DUT output.
module tb_clk_ratio_monitor;

  localparam int W_HALF     = 1;
  localparam int R_HALF     = 3;
  localparam int LOCK_COUNT = 4;
  localparam int CNT_W      = 8;
  localparam int SAT        = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_MEAS  = 1;
  localparam int M_LOCK  = 2;
  localparam int M_FAULT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             wclk_in = 1'b0;
  logic             rclk_in = 1'b0;
  logic             clr_err = 1'b0;
  logic             w_locked, r_locked, all_locked, w_fault, r_fault;
  logic [CNT_W-1:0] w_last_run, r_last_run;

  always #5 clk = ~clk;

  clk_ratio_monitor #(
    .W_HALF     (W_HALF),
    .R_HALF     (R_HALF),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wclk_in    (wclk_in),
    .rclk_in    (rclk_in),
    .clr_err    (clr_err),
    .w_locked   (w_locked),
    .r_locked   (r_locked),
    .all_locked (all_locked),
    .w_fault    (w_fault),
    .r_fault    (r_fault),
    .w_last_run (w_last_run),
    .r_last_run (r_last_run)
  );

  typedef struct {
    int mode;
    int good;
    int last_edge;
    int last_run;
    bit h1;
    bit h2;
  } chan_model_t;

  typedef struct {
    bit wl;
    bit rl;
    bit al;
    bit wf;
    bit rf;
    int wlr;
    int rlr;
  } expect_t;

  expect_t     sb[$];
  chan_model_t mw, mr;
  int          n;
  bit          prev_wl, prev_rl;

  bit w_lvl, r_lvl;
  int w_rem, r_rem, w_def, r_def;
  int w_q[$];
  int r_q[$];
  bit clr_req, clr_on_w_tog, coincide_done;

  int checks;
  int failures;

  int w_lock_at, r_lock_at, all_lock_at, w_fault_at, r_fault_at;
  bit any_fault, seen_wlr2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset(inout chan_model_t m);
    m.mode      = M_IDLE;
    m.good      = 0;
    m.last_edge = 1;
    m.last_run  = 0;
    m.h1        = 1'b0;
    m.h2        = 1'b0;
  endfunction

  // One clk edge: an edge of the monitored clock is seen two samples late; the
  // half-period is the distance in clk edges between consecutive detected edges.
  function automatic void model_step(inout chan_model_t m, input bit x, input bit clr,
                                     input int exp_half, input int now);
    bit edge_seen;
    int elapsed;
    int measured;
    bit stuck;
    bit bad;
    int old_mode;
    edge_seen = (m.h1 != m.h2);
    elapsed   = now - m.last_edge;
    measured  = (elapsed > SAT) ? SAT : elapsed;
    stuck     = !edge_seen && (elapsed == 2 * exp_half + 1);
    bad       = edge_seen && (measured != exp_half);
    old_mode  = m.mode;
    case (m.mode)
      M_IDLE: if (edge_seen) begin
        m.mode = M_MEAS;
        m.good = 0;
      end
      M_MEAS: begin
        if (bad || stuck) m.good = 0;
        else if (edge_seen) begin
          m.good++;
          if (m.good == LOCK_COUNT) m.mode = M_LOCK;
        end
      end
      M_LOCK: if (bad || stuck) m.mode = M_FAULT;
      default: if (clr && !(bad || stuck)) m.mode = M_IDLE;
    endcase
    if (edge_seen && old_mode != M_IDLE) m.last_run = measured;
    if (edge_seen) m.last_edge = now;
    m.h2 = m.h1;
    m.h1 = x;
  endfunction

  task automatic drive_step();
    bit      clr;
    expect_t e;
    if (w_rem == 0) begin
      w_lvl = ~w_lvl;
      w_rem = (w_q.size() > 0) ? w_q.pop_front() : w_def;
    end
    w_rem--;
    if (r_rem == 0) begin
      r_lvl = ~r_lvl;
      r_rem = (r_q.size() > 0) ? r_q.pop_front() : r_def;
    end
    r_rem--;
    clr     = clr_req;
    clr_req = 1'b0;
    if (clr_on_w_tog && (mw.h1 != mw.h2)) begin
      clr           = 1'b1;
      clr_on_w_tog  = 1'b0;
      coincide_done = 1'b1;
    end
    wclk_in = w_lvl;
    rclk_in = r_lvl;
    clr_err = clr;
    n++;
    model_step(mw, w_lvl, clr, W_HALF, n);
    model_step(mr, r_lvl, clr, R_HALF, n);
    e.wl    = (mw.mode == M_LOCK);
    e.rl    = (mr.mode == M_LOCK);
    e.wf    = (mw.mode == M_FAULT);
    e.rf    = (mr.mode == M_FAULT);
    e.wlr   = mw.last_run;
    e.rlr   = mr.last_run;
    e.al    = prev_wl & prev_rl;
    prev_wl = e.wl;
    prev_rl = e.rl;
    sb.push_back(e);
  endtask

  task automatic obs_clear();
    w_lock_at   = -1;
    r_lock_at   = -1;
    all_lock_at = -1;
    w_fault_at  = -1;
    r_fault_at  = -1;
    any_fault   = 1'b0;
    seen_wlr2   = 1'b0;
  endtask

  // Observes outputs mid-cycle (after the previous edge settled), then drives the next cycle.
  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (w_locked === 1'b1 && w_lock_at < 0) w_lock_at = n;
      if (r_locked === 1'b1 && r_lock_at < 0) r_lock_at = n;
      if (all_locked === 1'b1 && all_lock_at < 0) all_lock_at = n;
      if (w_fault === 1'b1 && w_fault_at < 0) w_fault_at = n;
      if (r_fault === 1'b1 && r_fault_at < 0) r_fault_at = n;
      if (w_fault !== 1'b0 || r_fault !== 1'b0) any_fault = 1'b1;
      if (w_last_run == 8'd2) seen_wlr2 = 1'b1;
      drive_step();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_w_locked", w_locked, 0);
    check("rst_r_locked", r_locked, 0);
    check("rst_all_locked", all_locked, 0);
    check("rst_w_fault", w_fault, 0);
    check("rst_r_fault", r_fault, 0);
    check("rst_w_last_run", w_last_run, 0);
    check("rst_r_last_run", r_last_run, 0);
    sb.delete();
    w_q.delete();
    r_q.delete();
    model_reset(mw);
    model_reset(mr);
    n            = 0;
    prev_wl      = 1'b0;
    prev_rl      = 1'b0;
    w_lvl        = 1'b0;
    r_lvl        = 1'b0;
    w_rem        = 0;
    r_rem        = 0;
    clr_req      = 1'b0;
    clr_on_w_tog = 1'b0;
    wclk_in      = 1'b0;
    rclk_in      = 1'b0;
    clr_err      = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_step();
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        check("w_locked", w_locked, e.wl);
        check("r_locked", r_locked, e.rl);
        check("all_locked", all_locked, e.al);
        check("w_fault", w_fault, e.wf);
        check("r_fault", r_fault, e.rf);
        check("w_last_run", w_last_run, e.wlr);
        check("r_last_run", r_last_run, e.rlr);
      end
    end
  end

  initial begin : stimulus
    int k;
    int later;
    checks        = 0;
    failures      = 0;
    w_def         = W_HALF;
    r_def         = R_HALF;
    coincide_done = 1'b0;

    // Clean divider clocks: lock bounds, combined flag lag, no faults.
    do_reset();
    obs_clear();
    run(40);
    check("w_lock_within_10", (w_lock_at > 0 && w_lock_at <= 10), 1);
    check("r_lock_within_24", (r_lock_at > 0 && r_lock_at <= 24), 1);
    later = (w_lock_at > r_lock_at) ? w_lock_at : r_lock_at;
    check("all_lock_lag", all_lock_at, later + 1);
    obs_clear();
    run(1000);
    check("no_fault_1000", any_fault, 0);

    // rclk stuck low while locked.
    for (int i = 0; i < 10; i++) begin
      if (r_lvl == 1'b1 && r_rem == 0) break;
      run(1);
    end
    check("r_stuck_setup", (r_lvl == 1'b1 && r_rem == 0), 1);
    k = n + 1;
    r_q.push_back(40);
    obs_clear();
    run(30);
    check("r_fault_timing", r_fault_at, k + 8);
    check("r_locked_after_stuck", r_locked, 0);
    check("w_locked_unaffected", w_locked, 1);
    check("w_fault_unaffected", w_fault, 0);
    run(40);
    check("r_fault_sticky", r_fault, 1);
    clr_req = 1'b1;
    run(2);
    check("r_fault_cleared", r_fault, 0);
    run(30);
    check("r_relocked", r_locked, 1);

    // A single short wclk half-period while locked.
    obs_clear();
    w_q.push_back(2);
    run(10);
    check("w_fault_short_run", w_fault, 1);
    check("w_last_run_2_seen", seen_wlr2, 1);
    run(60);
    check("w_fault_persists", w_fault, 1);
    clr_req = 1'b1;
    run(2);
    check("w_fault_cleared", w_fault, 0);
    run(20);
    check("w_relocked", w_locked, 1);

    // clr_err landing on a bad run keeps the fault.
    w_def = 2;
    run(20);
    check("w_fault_bad_clock", w_fault, 1);
    coincide_done = 1'b0;
    clr_on_w_tog  = 1'b1;
    run(6);
    check("coincide_issued", coincide_done, 1);
    check("w_fault_clr_coincide", w_fault, 1);
    w_def = W_HALF;
    run(6);
    clr_req = 1'b1;
    run(20);
    check("w_relock_after_coincide", w_locked, 1);

    // Reset while locked, then a short rclk run before first lock.
    run(20);
    check("all_locked_before_reset", all_locked, 1);
    do_reset();
    r_q = '{3, 3, 2, 3, 3, 3, 3};
    obs_clear();
    run(60);
    check("no_fault_prelock_glitch", any_fault, 0);
    check("w_relock_after_reset", (w_lock_at > 0 && w_lock_at <= 10), 1);
    check("r_relock_after_reset", r_locked, 1);

    // Randomised half-periods and clear pulses against the model.
    for (int i = 0; i < 2500; i++) begin
      if (w_q.size() == 0 && $urandom_range(0, 15) == 0)
        w_q.push_back(int'($urandom_range(1, 4)));
      if (r_q.size() == 0 && $urandom_range(0, 11) == 0)
        r_q.push_back(int'($urandom_range(2, 9)));
      if ($urandom_range(0, 39) == 0) clr_req = 1'b1;
      run(1);
    end
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
